// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller.
//
// Purpose:
//   Hazard codes carried on the 4-bit hazard_signal bus that every
//   inter-stage pipeline register consumes, plus the controller's state
//   encoding.
//
// Contents:
//   HZ_NONE / STALL_MMU / FLUSH_EARLY / FLUSH_ALL : hazard_signal codes
//   hzc_state_t                                   : RUN, MMU_WAIT, DRAIN
package hazard_ctrl_pkg;

    localparam logic [3:0] HZ_NONE     = 4'd0;
    localparam logic [3:0] STALL_MMU   = 4'd1;
    localparam logic [3:0] FLUSH_EARLY = 4'd2;
    localparam logic [3:0] FLUSH_ALL   = 4'd3;

    typedef enum logic [1:0] {
        HZC_RUN      = 2'd0,
        HZC_MMU_WAIT = 2'd1,
        HZC_DRAIN    = 2'd2
    } hzc_state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Hazard controller.
//
// Purpose:
//   Arbitrates traps, MMU translation stalls and taken-branch redirects into
//   one hazard code per cycle (priority trap > MMU > branch). It also
//   sequences the MMU wait, with a timeout, and the post-trap flush drain.
//   The outputs are Mealy: they are decoded from the registered state and
//   the current inputs, so a pipeline register sees the code on the edge
//   that ends the cycle.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset (outputs read 0 while rst=1)
//   mmu_req          IF/MEM stage needs translation this cycle
//   mmu_ready        MMU result valid (level, honoured in RUN hit check and MMU_WAIT)
//   branch_taken_ex  EX resolved a taken branch/jump (held by EX while stalled)
//   trap_req         exception/interrupt from MEM
//   hazard_signal    HZ_NONE / STALL_MMU / FLUSH_EARLY / FLUSH_ALL
//   pc_stall         PC holds this cycle
//   redirect_valid   PC loads the branch target (pulse)
//   trap_redirect    PC loads the trap vector (pulse)
//   mmu_abort        cancel the outstanding MMU request (pulse)
//   mmu_timeout      MMU timeout detected (pulse, cause to CSR)
//   dbg_state        current FSM state, for debug and checkers
//
// Handshake note: there is no valid/ready pairing here. Each request input
// is a level sampled every cycle, and each pulse output is asserted for
// exactly the one cycle in which its event is accepted.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MMU_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mmu_req,
    input  logic       mmu_ready,
    input  logic       branch_taken_ex,
    input  logic       trap_req,
    output logic [3:0] hazard_signal,
    output logic       pc_stall,
    output logic       redirect_valid,
    output logic       trap_redirect,
    output logic       mmu_abort,
    output logic       mmu_timeout,
    output hzc_state_t dbg_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(MMU_TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // A trap with a single drain cycle needs no DRAIN state at all.
    localparam hzc_state_t TRAP_NEXT = (DRAIN_CYCLES > 1) ? HZC_DRAIN : HZC_RUN;

    hzc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZC_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hazard_signal  = HZ_NONE;
        pc_stall       = 1'b0;
        redirect_valid = 1'b0;
        trap_redirect  = 1'b0;
        mmu_abort      = 1'b0;
        mmu_timeout    = 1'b0;

        // Outputs are held at zero while reset is asserted. The state
        // register is re-initialised by the flop reset.
        if (!rst) begin
            case (state_q)
                HZC_RUN: begin
                    if (trap_req) begin
                        hazard_signal = FLUSH_ALL;
                        trap_redirect = 1'b1;
                        cnt_d         = DRAIN_INIT;
                        state_d       = TRAP_NEXT;
                    end else if (mmu_req && !mmu_ready) begin
                        hazard_signal = STALL_MMU;
                        pc_stall      = 1'b1;
                        cnt_d         = CNT_ONE;
                        state_d       = HZC_MMU_WAIT;
                    end else if (branch_taken_ex) begin
                        // This branch is also reached on a same-cycle MMU hit.
                        hazard_signal  = FLUSH_EARLY;
                        redirect_valid = 1'b1;
                    end
                end

                HZC_MMU_WAIT: begin
                    if (trap_req) begin
                        hazard_signal = FLUSH_ALL;
                        trap_redirect = 1'b1;
                        mmu_abort     = 1'b1;
                        cnt_d         = DRAIN_INIT;
                        state_d       = TRAP_NEXT;
                    end else if (mmu_ready) begin
                        // A held branch is picked up from RUN on the next cycle.
                        cnt_d   = '0;
                        state_d = HZC_RUN;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        hazard_signal = FLUSH_ALL;
                        trap_redirect = 1'b1;
                        mmu_abort     = 1'b1;
                        mmu_timeout   = 1'b1;
                        cnt_d         = DRAIN_INIT;
                        state_d       = TRAP_NEXT;
                    end else begin
                        // cnt_q < TIMEOUT_C here, so the increment cannot wrap.
                        hazard_signal = STALL_MMU;
                        pc_stall      = 1'b1;
                        cnt_d         = cnt_q + CNT_ONE;
                    end
                end

                HZC_DRAIN: begin
                    hazard_signal = FLUSH_ALL;
                    // Leave on the cycle the counter reaches zero. The <= also
                    // keeps a zero count from wrapping.
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = HZC_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    cnt_d   = '0;
                    state_d = HZC_RUN;
                end
            endcase
        end
    end

endmodule
